// File: rtl/dot_vector_sequencer_if.sv
// Element-pair input stream and result output stream of the dot-product sequencer.
// Valid/ready: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.
interface dot_vector_sequencer_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dot_vector_sequencer.sv
// Collects H (a, b) pairs into operand vectors, kicks the dot-product stage,
// waits a fixed latency, then holds the captured result until downstream takes it.
module dot_vector_sequencer #(
    parameter int Q        = 15,
    parameter int N        = 32,
    parameter int H        = 10,
    parameter int WAIT_CYC = 34
) (
    input  logic                clk,
    input  logic                rst_n,
    dot_vector_sequencer_if.slave bus,
    output logic [H-1:0][N-1:0] a_vec,
    output logic [H-1:0][N-1:0] b_vec,
    output logic                start_dot,
    input  logic [N-1:0]        dot_result,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int IDX_W = (H > 1) ? $clog2(H) : 1;
    localparam int CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    if (H < 1) begin : g_bad_h
        $error("dot_vector_sequencer: H must be >= 1");
    end
    if (WAIT_CYC < 1) begin : g_bad_wait
        $error("dot_vector_sequencer: WAIT_CYC must be >= 1");
    end
    // Q only describes how downstream interprets the words; it must fit in one.
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("dot_vector_sequencer: Q must lie in [0, N-1]");
    end

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (bus.in_valid && idx == IDX_LAST) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Operand vectors only move on accepted FILL writes and are never cleared between vectors.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vec <= '0;
            b_vec <= '0;
            out_q <= '0;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (bus.in_valid) begin
                        a_vec[idx] <= bus.in_a;
                        b_vec[idx] <= bus.in_b;
                        idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end
                end
                S_START: cnt <= '0;
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        out_q <= dot_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every handshake output is a pure decode of the state register.
    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_data  = out_q;
    assign start_dot     = (state_q == S_START);
    assign busy          = (state_q != S_FILL);
    assign state_dbg     = state_q;

endmodule
